// File: rtl/uart_pad_port.sv
// uart_pad_port: per-channel UART pad adapter; rxd synchroniser, glitch filter, break detector, txd pad drive.
// Latency: rxd pin to io_uart_rxd is SYNC_STAGES+FILT_CYC edges; loopback and txd pad paths are combinational.
// Backpressure: none; every channel conditions its pins every cycle with no handshake.
module uart_pad_port #(
   parameter int N_CH        = 1,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC    = 3,
   parameter int BREAK_CYC   = 16,
   parameter int RX_PUE      = 1,
   parameter int TX_DS       = 0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N_CH-1:0] io_uart_txd,
   output logic [N_CH-1:0] io_uart_rxd,
   input  logic [N_CH-1:0] io_ctrl_loopback,
   input  logic [N_CH-1:0] io_ctrl_tx_en,
   input  logic [N_CH-1:0] io_break_clr,
   output logic [N_CH-1:0] io_break,
   input  logic [N_CH-1:0] io_pins_rxd_i_ival,
   output logic [N_CH-1:0] io_pins_rxd_o_oval,
   output logic [N_CH-1:0] io_pins_rxd_o_oe,
   output logic [N_CH-1:0] io_pins_rxd_o_ie,
   output logic [N_CH-1:0] io_pins_rxd_o_pue,
   output logic [N_CH-1:0] io_pins_rxd_o_ds,
   input  logic [N_CH-1:0] io_pins_txd_i_ival,
   output logic [N_CH-1:0] io_pins_txd_o_oval,
   output logic [N_CH-1:0] io_pins_txd_o_oe,
   output logic [N_CH-1:0] io_pins_txd_o_ie,
   output logic [N_CH-1:0] io_pins_txd_o_pue,
   output logic [N_CH-1:0] io_pins_txd_o_ds
);

   localparam int FW = $clog2(FILT_CYC + 1);
   localparam int BW = $clog2(BREAK_CYC + 1);
   localparam logic [FW-1:0] FC_LAST = FW'(FILT_CYC - 1);
   localparam logic [BW-1:0] BC_MAX  = BW'(BREAK_CYC);
   localparam logic [BW-1:0] BC_PRE  = BW'(BREAK_CYC - 1);

   // The txd pad input is never looked at; tie it off so it is visibly intentional.
   logic unused_txd_ival;
   assign unused_txd_ival = &{1'b0, io_pins_txd_i_ival};

   // rxd pad is a pure input with a configurable pull-up.
   assign io_pins_rxd_o_oval = '0;
   assign io_pins_rxd_o_oe   = '0;
   assign io_pins_rxd_o_ie   = '1;
   assign io_pins_rxd_o_pue  = {N_CH{(RX_PUE != 0)}};
   assign io_pins_rxd_o_ds   = '0;

   // txd pad is output-only; enable comes straight from the core.
   assign io_pins_txd_o_oe   = io_ctrl_tx_en;
   assign io_pins_txd_o_ie   = '0;
   assign io_pins_txd_o_pue  = '0;
   assign io_pins_txd_o_ds   = {N_CH{(TX_DS != 0)}};

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      logic                   f_q, f_d;
      logic [FW-1:0]          fc_q, fc_d;
      logic [BW-1:0]          bc_q, bc_d;
      logic                   brk_q, brk_d;

      // Idle line is high, so the synchroniser and filter come out of reset at 1.
      assign s = sync_q[SYNC_STAGES-1];

      // Filter accepts a new level only after it disagrees for FILT_CYC edges;
      // break counter runs off the filtered pad level regardless of loopback.
      always_comb begin
         f_d   = f_q;
         fc_d  = fc_q;
         bc_d  = bc_q;
         brk_d = brk_q;

         if (s == f_q) begin
            fc_d = '0;
         end else if (fc_q == FC_LAST) begin
            f_d  = s;
            fc_d = '0;
         end else begin
            fc_d = fc_q + FW'(1);
         end

         if (f_q) begin
            bc_d = '0;
         end else if (bc_q < BC_MAX) begin
            bc_d = bc_q + BW'(1);
         end

         // Set only on the single BREAK_CYC-1 -> BREAK_CYC step, so a cleared
         // flag cannot reassert while the counter sits saturated; set beats clear.
         if (!f_q && (bc_q == BC_PRE)) begin
            brk_d = 1'b1;
         end else if (io_break_clr[i]) begin
            brk_d = 1'b0;
         end
      end

      // Channel state registers with asynchronous reset to the idle-line values.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            sync_q <= '1;
            f_q    <= 1'b1;
            fc_q   <= '0;
            bc_q   <= '0;
            brk_q  <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_pins_rxd_i_ival[i]};
            f_q    <= f_d;
            fc_q   <= fc_d;
            bc_q   <= bc_d;
            brk_q  <= brk_d;
         end
      end

      assign io_uart_rxd[i]        = io_ctrl_loopback[i] ? io_uart_txd[i] : f_q;
      assign io_break[i]           = brk_q;
      // Pad idles high (UART mark) whenever it is not carrying core data.
      assign io_pins_txd_o_oval[i] = (io_ctrl_tx_en[i] & ~io_ctrl_loopback[i]) ? io_uart_txd[i] : 1'b1;
   end

endmodule

// File: tb/tb_uart_pad_port.sv
// tb_uart_pad_port: directed scenarios plus randomized pin/control traffic against a run-length reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_uart_pad_port;

   localparam int N_CH = 2;
   localparam int SYNC = 2;
   localparam int FILT = 3;
   localparam int BRK  = 16;

   logic clock = 1'b0;
   logic reset;
   logic [N_CH-1:0] io_uart_txd, io_uart_rxd, io_ctrl_loopback, io_ctrl_tx_en;
   logic [N_CH-1:0] io_break_clr, io_break;
   logic [N_CH-1:0] rxd_ival, rxd_oval, rxd_oe, rxd_ie, rxd_pue, rxd_ds;
   logic [N_CH-1:0] txd_ival, txd_oval, txd_oe, txd_ie, txd_pue, txd_ds;

   uart_pad_port #(
      .N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_CYC(FILT), .BREAK_CYC(BRK), .RX_PUE(1), .TX_DS(0)
   ) dut (
      .clock(clock), .reset(reset),
      .io_uart_txd(io_uart_txd), .io_uart_rxd(io_uart_rxd),
      .io_ctrl_loopback(io_ctrl_loopback), .io_ctrl_tx_en(io_ctrl_tx_en),
      .io_break_clr(io_break_clr), .io_break(io_break),
      .io_pins_rxd_i_ival(rxd_ival), .io_pins_rxd_o_oval(rxd_oval), .io_pins_rxd_o_oe(rxd_oe),
      .io_pins_rxd_o_ie(rxd_ie), .io_pins_rxd_o_pue(rxd_pue), .io_pins_rxd_o_ds(rxd_ds),
      .io_pins_txd_i_ival(txd_ival), .io_pins_txd_o_oval(txd_oval), .io_pins_txd_o_oe(txd_oe),
      .io_pins_txd_o_ie(txd_ie), .io_pins_txd_o_pue(txd_pue), .io_pins_txd_o_ds(txd_ds)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: pin history gives the synchronised sample, filter is a
   // disagreement run length, break is the length of the current low run.
   logic [N_CH-1:0] plog[$];
   bit m_f    [N_CH];
   int m_frun [N_CH];
   int m_lrun [N_CH];
   bit m_brk  [N_CH];

   function automatic void model_reset();
      plog.delete();
      for (int c = 0; c < N_CH; c++) begin
         m_f[c] = 1'b1; m_frun[c] = 0; m_lrun[c] = 0; m_brk[c] = 1'b0;
      end
   endfunction

   function automatic void model_edge();
      logic [N_CH-1:0] s_vec;
      bit f_old;
      s_vec = (plog.size() >= SYNC) ? plog[plog.size()-SYNC] : '1;
      plog.push_back(rxd_ival);
      if (plog.size() > SYNC) void'(plog.pop_front());
      for (int c = 0; c < N_CH; c++) begin
         f_old = m_f[c];
         if (!f_old) m_lrun[c]++;
         else        m_lrun[c] = 0;
         if (!f_old && m_lrun[c] == BRK) m_brk[c] = 1'b1;
         else if (io_break_clr[c])       m_brk[c] = 1'b0;
         if (s_vec[c] == f_old) begin
            m_frun[c] = 0;
         end else begin
            m_frun[c]++;
            if (m_frun[c] == FILT) begin
               m_f[c] = s_vec[c];
               m_frun[c] = 0;
            end
         end
      end
   endfunction

   task automatic check_all();
      logic [N_CH-1:0] e_rxd, e_brk, e_oval;
      for (int c = 0; c < N_CH; c++) begin
         e_rxd[c]  = io_ctrl_loopback[c] ? io_uart_txd[c] : m_f[c];
         e_brk[c]  = m_brk[c];
         e_oval[c] = (io_ctrl_tx_en[c] && !io_ctrl_loopback[c]) ? io_uart_txd[c] : 1'b1;
      end
      check("rxd_model", io_uart_rxd, e_rxd);
      check("break_model", io_break, e_brk);
      check("txd_oval", txd_oval, e_oval);
      check("txd_oe", txd_oe, io_ctrl_tx_en);
      check("rxd_pads", {rxd_oval, rxd_oe, rxd_ie, rxd_pue, rxd_ds}, 10'b00_00_11_11_00);
      check("txd_pads", {txd_ie, txd_pue, txd_ds}, 6'b0);
   endtask

   task automatic step();
      @(posedge clock);
      if (reset) model_reset();
      else       model_edge();
      #2;
      check_all();
   endtask

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic async_reset_pulse();
      #1 reset = 1'b1;
      model_reset();
      #1 check_all();
      #1 reset = 1'b0;
   endtask

   int lat, lows, fe, be, fe2, be2, hi_after_clr;
   int hold[N_CH];

   initial begin
      reset = 1'b1;
      io_uart_txd = '1; io_ctrl_loopback = '0; io_ctrl_tx_en = '1; io_break_clr = '0;
      rxd_ival = '1; txd_ival = '0;
      model_reset();
      #1 check_all();
      cyc(2);
      reset = 1'b0;
      check("reset_rxd", io_uart_rxd, 2'b11);
      check("reset_break", io_break, 2'b00);
      cyc(3);

      // Latency: ch0 falls on the 5th edge, ch1 stays idle
      rxd_ival = 2'b10; lat = -1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (lat < 0 && io_uart_rxd[0] == 1'b0) lat = k;
      end
      check("latency", lat, 5);
      check("ch1_idle", io_uart_rxd[1], 1);
      rxd_ival = '1; cyc(8);

      // Glitch: 2-cycle pulse rejected, 3-cycle pulse passes as 3 low cycles
      for (int w = 2; w <= 3; w++) begin
         rxd_ival[0] = 1'b0; lows = 0;
         for (int k = 0; k < w; k++) begin step(); if (!io_uart_rxd[0]) lows++; end
         rxd_ival[0] = 1'b1;
         for (int k = 0; k < 12; k++) begin step(); if (!io_uart_rxd[0]) lows++; end
         check(w == 2 ? "glitch2_lows" : "glitch3_lows", lows, w == 2 ? 0 : 3);
      end

      // Break: rises 16 edges after f falls, clr at cycle 25, stays cleared
      rxd_ival[0] = 1'b0; fe = -1; be = -1; hi_after_clr = 0;
      for (int k = 1; k <= 30; k++) begin
         io_break_clr[0] = (k == 25);
         step();
         io_break_clr[0] = 1'b0;
         if (fe < 0 && !io_uart_rxd[0]) fe = k;
         if (be < 0 && io_break[0]) be = k;
         if (k == 25) check("break_cleared", io_break[0], 0);
         if (k > 25 && io_break[0]) hi_after_clr++;
      end
      check("break_delay", be - fe, 16);
      rxd_ival[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin step(); if (io_break[0]) hi_after_clr++; end
      rxd_ival[0] = 1'b0; fe2 = -1; be2 = -1;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (fe2 < 0 && !io_uart_rxd[0]) fe2 = k;
         if (be2 < 0 && io_break[0]) be2 = k;
         if (be2 < 0 && io_break[0] == 1'b0) ;
         else if (be2 < 0) hi_after_clr++;
      end
      check("break_stayed_clear", hi_after_clr, 0);
      check("break2_delay", be2 - fe2, 16);

      // Set/clear collision: set wins
      io_break_clr[0] = 1'b1; step(); io_break_clr[0] = 1'b0;
      check("break_clr_pulse", io_break[0], 0);
      rxd_ival[0] = 1'b1; cyc(8);
      rxd_ival[0] = 1'b0; cyc(20);
      check("pre_collide", io_break[0], 0);
      io_break_clr[0] = 1'b1; step(); io_break_clr[0] = 1'b0;
      check("collide_set_wins", io_break[0], 1);
      io_break_clr[0] = 1'b1; step(); io_break_clr[0] = 1'b0;
      rxd_ival[0] = 1'b1; cyc(8);

      // Loopback and tx disable
      io_ctrl_loopback = '1;
      for (int k = 0; k < 8; k++) begin
         io_uart_txd = N_CH'($urandom);
         #1;
         check("lb_rxd", io_uart_rxd, io_uart_txd);
         check("lb_oval", txd_oval, 2'b11);
         step();
      end
      io_ctrl_loopback = '0; io_ctrl_tx_en = '0; io_uart_txd = 2'b00;
      #1;
      check("txdis_oe", txd_oe, 2'b00);
      check("txdis_oval", txd_oval, 2'b11);
      step();
      io_ctrl_tx_en = '1; io_uart_txd = '1;

      // Async reset mid-filter, with a break pending on ch1
      rxd_ival = 2'b01; cyc(25);
      check("ch1_break_before_rst", io_break[1], 1);
      rxd_ival = 2'b00; cyc(4);
      #1 reset = 1'b1;
      model_reset();
      #1;
      check("rst_imm_rxd", io_uart_rxd, 2'b11);
      check("rst_imm_break", io_break, 2'b00);
      #1 reset = 1'b0;
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (lat < 0 && io_uart_rxd[0] == 1'b0) lat = k;
      end
      check("post_rst_latency", lat, 5);
      rxd_ival = '1; io_break_clr = '1; step(); io_break_clr = '0; cyc(8);

      // Randomized traffic against the model
      for (int c = 0; c < N_CH; c++) hold[c] = $urandom_range(1, 40);
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < N_CH; c++) begin
            hold[c]--;
            if (hold[c] <= 0) begin
               rxd_ival[c] = ~rxd_ival[c];
               hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 40);
            end
         end
         io_uart_txd = N_CH'($urandom);
         if ($urandom_range(0, 15) == 0) io_ctrl_loopback = N_CH'($urandom);
         if ($urandom_range(0, 15) == 0) io_ctrl_tx_en = N_CH'($urandom);
         io_break_clr = ($urandom_range(0, 9) == 0) ? N_CH'($urandom) : '0;
         #1 check_all();
         if (n == 700) async_reset_pulse();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_pad_port.md
UART_PAD_PORT -- requirements
Module: uart_pad_port

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_CH, 1, number of independent UART pin channels; valid range 1..8.
- SYNC_STAGES, 2, rxd synchroniser depth; must be >= 2.
- FILT_CYC, 3, consecutive cycles a new rxd level must persist before it is accepted; must be >= 1.
- BREAK_CYC, 16, consecutive filtered-low cycles that flag a break; must be >= 2.
- RX_PUE, 1, constant value driven on the rxd pull-up enable.
- TX_DS, 0, constant value driven on the txd drive strength.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, sole clock; all flops are clocked on its rising edge.
- reset, in, 1, asynchronous, active-high.
- io_uart_txd, in, N_CH, serial transmit data from the UART cores.
- io_uart_rxd, out, N_CH, conditioned receive data to the UART cores.
- io_ctrl_loopback, in, N_CH, per-channel internal loopback enable.
- io_ctrl_tx_en, in, N_CH, per-channel txd pad output enable.
- io_break_clr, in, N_CH, per-channel clear pulse for the break flag.
- io_break, out, N_CH, per-channel sticky break flag.
- io_pins_rxd_i_ival, in, N_CH, rxd pad input value.
- io_pins_rxd_o_oval / _oe / _ie / _pue / _ds, out, N_CH each, rxd pad controls.
- io_pins_txd_i_ival, in, N_CH, txd pad input value; ignored.
- io_pins_txd_o_oval / _oe / _ie / _pue / _ds, out, N_CH each, txd pad controls.

Function
REQ-003 Channels SHALL be fully independent; bit i of every vector belongs to channel i.

REQ-004 rxd pad controls SHALL be constant:
- oval = 0, oe = 0, ie = 1, pue = RX_PUE, ds = 0.

REQ-005 io_pins_rxd_i_ival SHALL pass through a SYNC_STAGES-deep flop chain. Each flop resets to 1. The last stage is called s.

REQ-006 Each channel SHALL hold a filtered level f (reset 1) and a counter fc (reset 0, width clog2(FILT_CYC+1)). On each edge:
- if s == f: fc <= 0.
- else if fc == FILT_CYC-1: f <= s, fc <= 0.
- else: fc <= fc+1.

REQ-007 An rxd pin level change held stable SHALL reach f exactly SYNC_STAGES+FILT_CYC rising edges after the change is first sampled. Any pulse shorter than FILT_CYC cycles after synchronisation SHALL leave f unchanged.

REQ-008 io_uart_rxd SHALL be combinational:
- io_ctrl_loopback=1: io_uart_rxd = io_uart_txd.
- io_ctrl_loopback=0: io_uart_rxd = f.

REQ-009 txd pad controls SHALL be:
- oval = io_uart_txd when tx_en=1 and loopback=0, else 1.
- oe = io_ctrl_tx_en.
- ie = 0, pue = 0, ds = TX_DS.

REQ-010 Each channel SHALL have a break counter bc (width clog2(BREAK_CYC+1), reset 0):
- bc <= 0 when f == 1.
- bc <= bc+1 when f == 0 and bc < BREAK_CYC.
- bc holds at BREAK_CYC (saturates).

REQ-011 io_break SHALL behave as follows:
- Set (reset 0) on the edge where bc goes from BREAK_CYC-1 to BREAK_CYC.
- Cleared on any edge with io_break_clr=1.
- If set and clear occur on the same edge, set wins.
- Once cleared while the line stays low (bc saturated), it SHALL stay 0 until f returns to 1 and a new break occurs.

REQ-012 Break detection SHALL use f (the pad side) in both loopback modes.

REQ-013 Toggling loopback or tx_en SHALL take effect combinationally in the same cycle. The filter and break state SHALL be unaffected.

Reset
REQ-014 Asserting reset at any time SHALL immediately force all of the following, with no clock required:
- sync flops = 1, f = 1, fc = 0, bc = 0, io_break = 0.

REQ-015 While reset is asserted, outputs SHALL be:
- io_uart_rxd = 1 for channels with loopback=0.
- Pad controls per REQ-004 and REQ-009.

REQ-016 After reset deasserts, the first rising edge SHALL operate normally; no extra settling cycle.

Verification
REQ-017 The bench SHALL cover these scenarios (SYNC_STAGES=2, FILT_CYC=3, BREAK_CYC=16, N_CH=2 unless noted):
- Latency: pin falls 1->0 and is held; ch0 io_uart_rxd falls on the 5th edge after first sampling; ch1 is unaffected.
- Glitch: a 2-cycle low pulse on rxd leaves io_uart_rxd at 1 throughout; a 3-cycle low pulse produces exactly 3 cycles of low.
- Break: rxd held low for 30 cycles; io_break rises 16 edges after f falls. A clr pulse at cycle 25 drops it, and it stays 0 until the line goes high and then low for 16 more cycles.
- Set/clear collision: io_break_clr asserted on the set edge; io_break = 1 afterwards.
- Loopback and tx disable: loopback=1, txd toggling gives io_uart_rxd == io_uart_txd and txd oval = 1. With tx_en=0, txd oe = 0 and oval = 1.
- Async reset mid-filter: reset asserted when fc = 2 with pin low; f = 1, fc = 0 and io_break = 0 immediately. After release, the pin still low gives a fall after 5 edges.
